// File: rtl/qam_demapper_if.sv
// Stream bundle for the 16-QAM demapper: FFT bins in, packed symbol words out.
// Modport slave is the demapper's view; master is the driving environment's view.
interface qam_demapper_if #(
    parameter int unsigned B = 8
) ();
    logic [31:0]  s_data_in;
    logic         s_dvalid;
    logic         s_dlast;
    logic         s_dready;
    logic [B-1:0] m_data_out;
    logic         m_dvalid;
    logic         m_dready;

    modport slave (
        input  s_data_in, s_dvalid, s_dlast, m_dready,
        output s_dready, m_data_out, m_dvalid
    );

    modport master (
        output s_data_in, s_dvalid, s_dlast, m_dready,
        input  s_dready, m_data_out, m_dvalid
    );
endinterface

// File: rtl/qam_demapper.sv
// Hard-decision 16-QAM demapper: slices enabled FFT data bins and packs symbols MSB-first.
// Define QAM_DEMAP_EVM_EN to add a per-frame saturating error-magnitude accumulator.
module qam_demapper #(
    parameter int unsigned B      = 8,
    parameter int unsigned N      = 8,
    parameter int unsigned LOG2M  = 4,
    parameter int unsigned THRESH = 21770
) (
    input  logic       aclk,
    input  logic       reset,
    qam_demapper_if.slave bus,
    input  logic [7:0] carrier_control,
    output logic       frame_err
`ifdef QAM_DEMAP_EVM_EN
    ,
    output logic [23:0] evm_acc,
    output logic        evm_valid
`endif
);
    localparam int unsigned Frame = 2 * N;
    localparam int unsigned IdxW  = $clog2(Frame);
    localparam int unsigned CntW  = $clog2(B + 1);
    localparam logic [16:0] Thresh = 17'(THRESH);

    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [B-1:0]    pack_q, pack_d, data_q, data_d;
    logic [7:0]      mask_q, mask_d;
    logic            valid_q, valid_d, err_q, err_d;

    logic            accept, last_beat, is_data;
    logic [15:0]     re, im;
    logic [16:0]     abs_re, abs_im;
    logic            big_re, big_im;
    logic [3:0]      sym;

    assign bus.s_dready   = ~valid_q | bus.m_dready;
    assign bus.m_dvalid   = valid_q;
    assign bus.m_data_out = data_q;
    assign frame_err      = err_q;

    assign accept    = bus.s_dvalid & bus.s_dready;
    assign last_beat = (idx_q == IdxW'(Frame - 1)) | bus.s_dlast;
    assign is_data   = (idx_q != '0) && (idx_q < IdxW'(N)) && mask_q[3'(idx_q)];

    // 17-bit magnitudes so that -32768 maps to +32768 without overflow.
    assign re     = bus.s_data_in[31:16];
    assign im     = bus.s_data_in[15:0];
    assign abs_re = re[15] ? (17'h10000 - {1'b0, re}) : {1'b0, re};
    assign abs_im = im[15] ? (17'h10000 - {1'b0, im}) : {1'b0, im};
    assign big_re = abs_re >= Thresh;
    assign big_im = abs_im >= Thresh;
    assign sym    = {~re[15], ~big_re, ~im[15], ~big_im};

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        data_d  = data_q;
        mask_d  = mask_q;
        err_d   = err_q;
        valid_d = valid_q & ~bus.m_dready;
        if (accept) begin
            idx_d = last_beat ? '0 : idx_q + 1'b1;
            if (idx_q == '0) mask_d = carrier_control;
            if (bus.s_dlast != (idx_q == IdxW'(Frame - 1))) err_d = 1'b1;
            if (is_data) begin
                pack_d = (pack_q << LOG2M) | B'(sym);
                if (cnt_q + CntW'(LOG2M) == CntW'(B)) begin
                    data_d  = pack_d;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(LOG2M);
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef QAM_DEMAP_EVM_EN
    logic [16:0] lvl_re, lvl_im, dev_re, dev_im;
    logic [24:0] total;
    logic [23:0] sum_q, sum_d, sat, acc_d;
    logic        ev_d;

    always_comb begin
        lvl_re = big_re ? 17'd32736 : 17'd10803;
        lvl_im = big_im ? 17'd32736 : 17'd10803;
        dev_re = (abs_re >= lvl_re) ? abs_re - lvl_re : lvl_re - abs_re;
        dev_im = (abs_im >= lvl_im) ? abs_im - lvl_im : lvl_im - abs_im;
        total  = {1'b0, sum_q} + (is_data ? 25'(dev_re) + 25'(dev_im) : 25'd0);
        sat    = total[24] ? 24'hFFFFFF : total[23:0];
        sum_d  = sum_q;
        acc_d  = evm_acc;
        ev_d   = 1'b0;
        if (accept) begin
            if (last_beat) begin
                acc_d = sat;
                ev_d  = 1'b1;
                sum_d = '0;
            end else begin
                sum_d = sat;
            end
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sum_q     <= '0;
            evm_acc   <= '0;
            evm_valid <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            evm_acc   <= acc_d;
            evm_valid <= ev_d;
        end
    end
`endif
endmodule

// File: doc/qam_demapper.md
Name: qam_demapper

Overview:
- Receive-side counterpart of the OFDM 16-QAM transmit mapper.
- Consumes one FFT output frame per OFDM symbol: 2N complex bins, each a 32-bit {re, im} word on an AXI-stream-like slave.
- Hard-slices the enabled data carriers 1..N-1 to 4-bit 16-QAM symbols, using the same Gray-free index layout as the TX lookup table.
- Packs the symbols MSB-first into B-bit words on a valid/ready master port.

Parameters:
- B, 8, output word width; must be a multiple of LOG2M and at least LOG2M.
- N, 8, data bins per half-frame; a frame is 2N bins.
- LOG2M, 4, bits per symbol; fixed at 4 (16-QAM).
- THRESH, 21770, magnitude decision boundary between the 10803 and 32736 levels.

Ports:
- aclk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- carrier_control  in  8  bit k enables carrier k (k=1..N-1); bits 0 and N are ignored
- s_data_in  in  32  bin sample: [31:16] re, [15:0] im, signed two's complement
- s_dvalid  in  1  sample valid
- s_dlast  in  1  last bin of frame
- s_dready  out  1  sample accepted when s_dvalid & s_dready
- m_data_out  out  B  packed symbol word
- m_dvalid  out  1  word valid; held until accepted
- m_dready  in  1  downstream ready
- frame_err  out  1  sticky framing-error flag

Behaviour:
- Reset values: s_dready=1, m_dvalid=0, m_data_out=0, frame_err=0. Bin index, bit count, packing register and latched carrier mask all clear to 0. Reset mid-frame discards the partial frame and the residue bits.
- s_dready = ~m_dvalid | m_dready, combinational from registered state.
  - Each accepted bin adds at most 4 bits, so at most one word completes per beat.
  - No skid buffer is required.
- Bin index idx (0..2N-1):
  - Increments on every accepted beat.
  - Wraps to 0 after idx=2N-1 or after any beat with s_dlast=1.
  - carrier_control is latched on the idx=0 beat and applies to the whole frame.
- Data bin: idx in 1..N-1 with latched mask bit idx set. All other bins are discarded: bin 0, bin N, the mirrored bins N+1..2N-1, and disabled carriers.
- Slicing, per data bin:
  - Compute |re| and |im| in 17 bits, so -32768 maps to 32768.
  - sr = ~re[15]; br = (|re| >= THRESH). Same for im: si, bi.
  - Symbol = {sr, ~br, si, ~bi}.
  - This inverts the TX table: -32736 gives 00, -10803 gives 01, +32736 gives 10, +10803 gives 11 for each axis.
  - A value of exactly 0 slices as positive.
- Packing:
  - pack <= {pack[B-5:0], sym}; bitcnt += 4.
  - When bitcnt reaches B: m_data_out <= the new pack value, m_dvalid <= 1 on the next edge, bitcnt <= 0.
  - Latency: accept edge of the completing bin to m_dvalid high is 1 cycle.
  - Residue bits carry across frame boundaries and are never flushed except by reset.
- m_dvalid clears on the edge where m_dvalid & m_dready, unless a new word completes on the same edge, in which case m_data_out updates and m_dvalid stays 1.
- Framing errors set frame_err=1 (cleared only by reset), and idx wraps to 0 in both cases:
  - s_dlast=1 with idx != 2N-1.
  - idx=2N-1 accepted with s_dlast=0.
- Whenever s_dready=0, input is stalled and no state advances. m_data_out is stable while m_dvalid=1 and m_dready=0.

Optional Feature:
- Macro: QAM_DEMAP_EVM_EN.
- Defined: adds ports evm_acc (out, 24 bits) and evm_valid (out, 1 bit).
  - Per data bin, error = | |re| - L(re) | + | |im| - L(im) |, where L is 32736 if big else 10803.
  - Errors are accumulated per frame, saturating at 0xFFFFFF.
  - On the accept edge of the frame's final beat (idx=2N-1 or s_dlast), evm_acc is loaded with the frame total. evm_valid pulses 1 for one cycle, and the internal sum clears.
  - Reset: evm_acc=0, evm_valid=0.
- Undefined: no ports, no logic.

Test Plan:
- Two frames, carrier_control=0xFE, no backpressure.
  - Frame 1 bins 1..7 carry LUT points for symbols 1..7; frame 2 carries 8..E. Bins 0, 8 and 9..15 carry garbage.
  - Required output: 0x12, 0x34, 0x56, 0x78, 0x9A, 0xBC, 0xDE, each m_dvalid 1 cycle after the completing bin; frame_err=0.
- Thresholds.
  - re=+21769, im=-21770 gives symbol 0b1100=0xC. re=-32768, im=0 gives 0b0011=0x3.
  - Verify via a paired bin forming 0xC3.
- Backpressure.
  - m_dready held 0 for 5 cycles while 0x12 is pending: s_dready drops once 0x12 is pending and stays low until m_dready rises.
  - m_data_out holds 0x12 throughout; no bins are lost, and the following words match the no-stall run.
- Carrier mask.
  - carrier_control=0x0A with symbols 0xA on bin 1 and 0x5 on bin 3: one word 0xA5 per frame; the mask change takes effect only at the next idx=0.
- Framing error.
  - s_dlast on idx=5: frame_err=1, the next beat is treated as idx=0.
  - 16 beats with no s_dlast: frame_err stays 1 and idx wraps.
- Reset mid-frame.
  - Assert reset after bin 3 with residue pending: all outputs return to reset values; the next frame's first word is formed only from its own symbols.
